// File: rtl/crtc_vram_pkg.sv
// Shared types and constants for the CRTC VRAM arbiter slice.
package crtc_vram_pkg;

    localparam int PH_W        = $clog2(16);
    localparam int VRAM_AW_DEF = 14;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_PEND = 2'd1,
        C_WAIT = 2'd2,
        C_DONE = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/crtc_slot_timer.sv
// Free-running character-phase counter with slot-0 and last-phase decodes.
module crtc_slot_timer
    import crtc_vram_pkg::*;
#(
    parameter int PHASES = 4
)(
    input  logic            clk,
    input  logic            rst,
    output logic [PH_W-1:0] o_ph,
    output logic            o_slot0,
    output logic            o_last
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    logic [PH_W-1:0] ph_q, ph_d;

    always_comb begin
        ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign o_ph    = ph_q;
    assign o_slot0 = (ph_q == '0);
    assign o_last  = (ph_q == PH_LAST);

endmodule

// File: rtl/crtc_vram_arb.sv
// VRAM arbiter and character-slot sequencer: phase 0 feeds the display, other phases serve the CPU.
// Build macro CRTC_VRAM_ARB_BLANK_ONLY_EN restricts CPU access to blanking periods.
module crtc_vram_arb
    import crtc_vram_pkg::*;
#(
    parameter int PHASES = 4,
    parameter int AW     = VRAM_AW_DEF
)(
    input  logic            I_CLK,
    input  logic            I_RST,
    output logic            O_CCLK_EN,
    input  logic [AW-1:0]   I_MA,
    input  logic            I_DISPTMG,
    output logic [7:0]      O_VID_DATA,
    output logic            O_VID_VLD,
    input  logic            I_CPU_REQ,
    input  logic            I_CPU_WE,
    input  logic [AW-1:0]   I_CPU_ADDR,
    input  logic [7:0]      I_CPU_DO,
    output logic [7:0]      O_CPU_DI,
    output logic            O_CPU_ACK,
    output logic            O_RAM_CS,
    output logic            O_RAM_WE,
    output logic [AW-1:0]   O_RAM_ADDR,
    output logic [7:0]      O_RAM_DI,
    input  logic [7:0]      I_RAM_DO,
    output cpu_state_e      O_DBG_STATE,
    output logic [PH_W-1:0] O_DBG_PH
);

    // CPU handshake (4-phase): REQ rises with WE/ADDR/DO stable and holds until ACK;
    // ACK holds until REQ falls; a new REQ may rise the cycle after ACK falls.

    cpu_state_e    state_q, state_d;
    logic          cpu_we_q, cpu_we_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]    cpu_do_q, cpu_do_d;
    logic [7:0]    cpu_di_q, cpu_di_d;
    logic          vid_pend_q, vid_pend_d;
    logic          vid_vld_q, vid_vld_d;
    logic [7:0]    vid_data_q, vid_data_d;

    logic slot0, vid_slot, free_ph, cpu_grant;

    crtc_slot_timer #(.PHASES(PHASES)) u_slot_timer (
        .clk     (I_CLK),
        .rst     (I_RST),
        .o_ph    (O_DBG_PH),
        .o_slot0 (slot0),
        .o_last  (O_CCLK_EN)
    );

    assign vid_slot = slot0 & I_DISPTMG;

`ifdef CRTC_VRAM_ARB_BLANK_ONLY_EN
    // Display state is held from the last phase 0 so mid-character changes are ignored.
    logic disp_q, disp_d;

    always_comb begin
        disp_d = slot0 ? I_DISPTMG : disp_q;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            disp_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign free_ph = slot0 ? ~I_DISPTMG : ~disp_q;
`else
    assign free_ph = ~vid_slot;
`endif

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (I_CPU_REQ) state_d = C_PEND;
            C_PEND:  if (cpu_grant) state_d = C_WAIT;
            C_WAIT:  state_d = C_DONE;
            C_DONE:  if (!I_CPU_REQ) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // Video owns phase 0 during display; the pending CPU access takes any other free phase.
    always_comb begin
        cpu_grant  = 1'b0;
        O_RAM_CS   = 1'b0;
        O_RAM_WE   = 1'b0;
        O_RAM_ADDR = '0;
        O_RAM_DI   = 8'h00;
        O_CPU_ACK  = (state_q == C_DONE);
        if (vid_slot) begin
            O_RAM_CS   = 1'b1;
            O_RAM_ADDR = I_MA;
        end else if ((state_q == C_PEND) && free_ph) begin
            cpu_grant  = 1'b1;
            O_RAM_CS   = 1'b1;
            O_RAM_WE   = cpu_we_q;
            O_RAM_ADDR = cpu_addr_q;
            O_RAM_DI   = cpu_we_q ? cpu_do_q : 8'h00;
        end
    end

    always_comb begin
        cpu_we_d   = cpu_we_q;
        cpu_addr_d = cpu_addr_q;
        cpu_do_d   = cpu_do_q;
        if ((state_q == C_IDLE) && I_CPU_REQ) begin
            cpu_we_d   = I_CPU_WE;
            cpu_addr_d = I_CPU_ADDR;
            cpu_do_d   = I_CPU_DO;
        end
        cpu_di_d   = ((state_q == C_WAIT) && !cpu_we_q) ? I_RAM_DO : cpu_di_q;
        vid_pend_d = vid_slot;
        vid_vld_d  = vid_pend_q;
        vid_data_d = vid_pend_q ? I_RAM_DO : vid_data_q;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_do_q   <= 8'h00;
            cpu_di_q   <= 8'h00;
            vid_pend_q <= 1'b0;
            vid_vld_q  <= 1'b0;
            vid_data_q <= 8'h00;
        end else begin
            cpu_we_q   <= cpu_we_d;
            cpu_addr_q <= cpu_addr_d;
            cpu_do_q   <= cpu_do_d;
            cpu_di_q   <= cpu_di_d;
            vid_pend_q <= vid_pend_d;
            vid_vld_q  <= vid_vld_d;
            vid_data_q <= vid_data_d;
        end
    end

    assign O_CPU_DI    = cpu_di_q;
    assign O_VID_DATA  = vid_data_q;
    assign O_VID_VLD   = vid_vld_q;
    assign O_DBG_STATE = state_q;

endmodule

// File: doc/crtc_vram_arb.md
# crtc_vram_arb

Video-RAM arbiter and character-slot sequencer for the CRTC6845-compatible display path. It divides each character period into a fixed number of system-clock phases and emits the character-clock enable that advances the CRTC. It reserves phase 0 for the display fetch at the CRTC's memory address while display timing is active, and grants every other phase to a single CPU port through a 4-phase req/ack handshake. It sits between the CRTC, the shared single-port synchronous VRAM (1-cycle read latency) and the CPU bus bridge.

## Interface
Parameters:
- PHASES, 4, system clocks per character period; legal range 2..16.
- AW, 14, VRAM address width; matches the CRTC MA width.

Ports:
- I_CLK  in  1  system clock; all logic on rising edge.
- I_RST  in  1  asynchronous, active-high reset.
- O_CCLK_EN  out  1  character-clock enable to the CRTC; high during phase PHASES-1.
- I_MA  in  AW  CRTC memory address, start address already added.
- I_DISPTMG  in  1  CRTC display-enable.
- O_VID_DATA  out  8  fetched display byte.
- O_VID_VLD  out  1  one-cycle strobe; O_VID_DATA is new.
- I_CPU_REQ  in  1  CPU access request; held until ack.
- I_CPU_WE  in  1  1 = write, 0 = read; sampled with REQ.
- I_CPU_ADDR  in  AW  CPU address; sampled with REQ.
- I_CPU_DO  in  8  CPU write data; sampled with REQ.
- O_CPU_DI  out  8  CPU read data; valid while ACK is high.
- O_CPU_ACK  out  1  high from access completion until REQ is low.
- O_RAM_CS, O_RAM_WE  out  1  VRAM strobes.
- O_RAM_ADDR  out  AW  VRAM address.
- O_RAM_DI  out  8  VRAM write data.
- I_RAM_DO  in  8  VRAM read data, valid 1 cycle after a read cycle.

## Operation
- Phase counter R_PH runs 0..PHASES-1 and wraps to 0. It is free-running and is not gated by DISPTMG.
- Video slot: when R_PH==0 and I_DISPTMG=1:
  - O_RAM_CS=1, O_RAM_WE=0, O_RAM_ADDR=I_MA.
  - I_RAM_DO is registered into O_VID_DATA at the end of the following cycle.
  - O_VID_VLD pulses in the cycle after that registration.
- CPU FSM states:
  - C_IDLE: on REQ=1, latch WE/ADDR/DO, go to C_PEND.
  - C_PEND: in the first free phase, drive the RAM from the latched values, go to C_WAIT.
  - C_WAIT: register I_RAM_DO into O_CPU_DI (reads only; O_CPU_DI is unchanged on writes), go to C_DONE.
  - C_DONE: ACK=1; when REQ=0, go to C_IDLE.
- Free phase: R_PH!=0, or I_DISPTMG=0. During blanking every phase, including phase 0, is free.
- RAM output mux is combinational from registered state, R_PH, I_MA and I_DISPTMG. Video always wins phase 0 while display is active. Both sides never drive the RAM in the same cycle.
- REQ dropping before ACK is a protocol violation; no required behaviour.
- Idle RAM outputs: CS=0, WE=0, ADDR=0, DI=0.

## Timing
- Reset values: R_PH=0, FSM=C_IDLE, O_CCLK_EN=0, O_VID_VLD=0, O_VID_DATA=0, O_CPU_ACK=0, O_CPU_DI=0, all O_RAM_* = 0.
- Reset mid-access: the FSM aborts to C_IDLE and ACK drops immediately. An in-flight write may or may not have reached the RAM.
- Video latency: fetch in cycle t (phase 0), O_VID_DATA updated at edge t+2, O_VID_VLD high in cycle t+2.
- CPU best case, with REQ first seen at edge t:
  - grant in cycle t+1;
  - ACK high from cycle t+3.
- CPU worst case: REQ lands while phase 0 is active with DISPTMG=1, which adds exactly one cycle.
- REQ re-asserted in the cycle after ACK falls is accepted normally. Back-to-back accesses therefore take at least 4 cycles.
- DISPTMG is sampled only in phase 0. A DISPTMG change in any other phase has no effect on arbitration until the next phase 0.

## Configuration
- CRTC_VRAM_ARB_BLANK_ONLY_EN
  - Defined: a phase is free only when I_DISPTMG=0. The CPU waits out all active display (snow-free, legacy-board behaviour).
  - Undefined: free-phase rule as in Operation.

## Structure
- Package crtc_vram_pkg holds:
  - the CPU FSM state enum (C_IDLE, C_PEND, C_WAIT, C_DONE);
  - the phase-width constant PH_W = clog2(16);
  - the default AW.
- One sub-module, crtc_slot_timer, holds the phase counter and the O_CCLK_EN / slot-0 decode. The arbiter FSM and RAM mux stay at top level.

## Test plan
- Reset, then 8 cycles with PHASES=4 -> O_CCLK_EN high in cycles 3 and 7; all other outputs at their reset values.
- DISPTMG=1, MA=0x0123, RAM returns 0x5A -> RAM_ADDR=0x0123 in phase 0; O_VID_DATA=0x5A with VLD two cycles later.
- CPU write 0xA5 to 0x0200, REQ at phase 3 with DISPTMG=1 -> RAM WE in phase 0 is deferred to phase 1; ACK 2 cycles after the grant; the video fetch is intact.
- CPU read during blanking, REQ at phase 3 -> grant in phase 0; O_CPU_DI = RAM data; ACK held until REQ drops, then 0 next cycle.
- Reset pulsed while in C_WAIT -> ACK=0 and FSM=C_IDLE immediately; a new request afterwards completes normally.
- Build with CRTC_VRAM_ARB_BLANK_ONLY_EN, REQ during display -> no grant until DISPTMG=0; grant in the first cycle after DISPTMG=0 is sampled.
